tiger_writeback_arb: RTL and testbench

//  Parametrised writeback stage. Merges the in-order pipeline result with NUM_CH
//  out-of-order result channels (e.g. mul/div, coprocessor) onto the single

---
 rtl/tiger_writeback_arb.sv | 179 +++++++++++++++++
 tb/tb_tiger_writeback_arb.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiger_writeback_arb.sv
// Writeback arbiter: merges the in-order pipeline result with NUM_CH queued
// out-of-order channel results onto one registered register-file write port.
module tiger_writeback_arb #(
  parameter int NUM_CH       = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wb_valid,
  input  logic                        wb_regwrite,
  input  logic                        wb_copwrite,
  input  logic [4:0]                  wb_regnum,
  input  logic                        wb_link,
  input  logic [31:0]                 wb_branchout,
  input  logic [31:0]                 wb_data,
  input  logic [1:0]                  wb_ld_size,
  input  logic                        wb_ld_signed,
  input  logic [1:0]                  wb_ld_off,
  input  logic [NUM_CH-1:0]           ch_valid,
  input  logic [5*NUM_CH-1:0]         ch_regnum,
  input  logic [32*NUM_CH-1:0]        ch_data,
  output logic [NUM_CH-1:0]           ch_ready,
  output logic                        pipe_stall,
  output logic                        writeRegEn,
  output logic                        writeRegEnCop,
  output logic [4:0]                  writeRegNum,
  output logic [31:0]                 writeRegData,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  regnum;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t     mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          wr_en_q, wr_en_d, wr_cop_q, wr_cop_d;
  logic [4:0]    wr_num_q, wr_num_d;
  logic [31:0]   wr_data_q, wr_data_d;

  logic          fifo_empty, fifo_full, starved;
  logic          pipe_req, pipe_sel, fifo_sel, enq;
  logic [PW-1:0] gnt_idx, cand;
  wb_entry_t     head, enq_entry;

  logic [4:0]    ch_reg_a [NUM_CH];
  logic [31:0]   ch_dat_a [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_reg_a[i] = ch_regnum[5*i +: 5];
    assign ch_dat_a[i] = ch_data[32*i +: 32];
  end

  // Big-endian lane select followed by zero/sign extension.
  function automatic logic [31:0] load_extract(input logic [31:0] d, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[15:0] : d[31:16];
    case (size)
      2'd0:    return {{24{sgn & b[7]}}, b};
      2'd1:    return {{16{sgn & h[15]}}, h};
      default: return d;
    endcase
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign starved    = !fifo_empty && (starve_q >= SW'(STARVE_LIMIT));
  // Stall on a full queue with a pending offer, otherwise nothing ever drains it.
  assign pipe_stall = reset_n && (starved || (fifo_full && (|ch_valid)));
  assign pipe_req   = wb_valid && (wb_regwrite || wb_copwrite);
  assign pipe_sel   = pipe_req && !pipe_stall;
  assign fifo_sel   = !pipe_sel && !fifo_empty;
  assign head       = mem_q[rd_ptr_q];

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    enq      = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    ch_ready = '0;
    if (reset_n && !fifo_full) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cand = PW'((int'(rr_ptr_q) + k) % NUM_CH);
        if (!enq && ch_valid[cand]) begin
          enq     = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (enq) ch_ready[gnt_idx] = 1'b1;
    rr_ptr_d  = enq ? PW'((int'(gnt_idx) + 1) % NUM_CH) : rr_ptr_q;
    enq_entry = {ch_reg_a[gnt_idx], ch_dat_a[gnt_idx]};
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_cop_d  = 1'b0;
    wr_num_d  = '0;
    wr_data_d = '0;
    if (pipe_sel) begin
      wr_en_d   = wb_regwrite && (wb_regnum != 5'd0);
      wr_cop_d  = wb_copwrite;
      wr_num_d  = wb_regnum;
      wr_data_d = wb_link ? wb_branchout
                          : load_extract(wb_data, wb_ld_size, wb_ld_signed, wb_ld_off);
    end else if (fifo_sel) begin
      wr_en_d   = (head.regnum != 5'd0);
      wr_num_d  = head.regnum;
      wr_data_d = head.data;
    end
  end

  always_comb begin
    wr_ptr_d = enq      ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = fifo_sel ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (enq && !fifo_sel)      count_d = count_q + CW'(1);
    else if (!enq && fifo_sel) count_d = count_q - CW'(1);
    starve_d = starve_q;
    if (fifo_sel || fifo_empty) starve_d = '0;
    else if (pipe_sel)          starve_d = starve_q + SW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      rr_ptr_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_cop_q  <= 1'b0;
      wr_num_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      rr_ptr_q  <= rr_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_cop_q  <= wr_cop_d;
      wr_num_q  <= wr_num_d;
      wr_data_q <= wr_data_d;
    end
  end

  // NOTE: queue storage is not reset; resetting the pointers and count is enough
  // to make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= enq_entry;
  end

  assign writeRegEn    = wr_en_q;
  assign writeRegEnCop = wr_cop_q;
  assign writeRegNum   = wr_num_q;
  assign writeRegData  = wr_data_q;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_tiger_writeback_arb.sv
// Bench for tiger_writeback_arb: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_tiger_writeback_arb;

  localparam int NUM_CH       = 2;
  localparam int FIFO_DEPTH   = 4;
  localparam int STARVE_LIMIT = 8;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 wb_valid, wb_regwrite, wb_copwrite, wb_link, wb_ld_signed;
  logic [4:0]           wb_regnum;
  logic [31:0]          wb_branchout, wb_data;
  logic [1:0]           wb_ld_size, wb_ld_off;
  logic [NUM_CH-1:0]    ch_valid;
  logic [5*NUM_CH-1:0]  ch_regnum;
  logic [32*NUM_CH-1:0] ch_data;
  logic [NUM_CH-1:0]    ch_ready;
  logic                 pipe_stall, writeRegEn, writeRegEnCop;
  logic [4:0]           writeRegNum;
  logic [31:0]          writeRegData;
  logic [2:0]           fifo_count;

  always #5 clk = ~clk;

  tiger_writeback_arb #(
    .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_copwrite(wb_copwrite),
    .wb_regnum(wb_regnum), .wb_link(wb_link), .wb_branchout(wb_branchout),
    .wb_data(wb_data), .wb_ld_size(wb_ld_size), .wb_ld_signed(wb_ld_signed),
    .wb_ld_off(wb_ld_off), .ch_valid(ch_valid), .ch_regnum(ch_regnum),
    .ch_data(ch_data), .ch_ready(ch_ready), .pipe_stall(pipe_stall),
    .writeRegEn(writeRegEn), .writeRegEnCop(writeRegEnCop),
    .writeRegNum(writeRegNum), .writeRegData(writeRegData), .fifo_count(fifo_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Channel stimulus: each channel offers c_todo results, payload derived from c_seq.
  logic [4:0]        c_reg [NUM_CH];
  logic [31:0]       c_dat [NUM_CH];
  int                c_todo [NUM_CH];
  int                c_seq [NUM_CH];
  logic [NUM_CH-1:0] acc_seen = '0;

  always @(negedge clk) acc_seen = ch_ready;

  task automatic apply_ch();
    for (int i = 0; i < NUM_CH; i++) begin
      c_reg[i] = 5'(8 + 8*i + (c_seq[i] % 8));
      c_dat[i] = 32'hC000_0000 | (32'(i) << 24) | 32'(c_seq[i]);
      ch_valid[i] = (c_todo[i] > 0);
      ch_regnum[5*i +: 5] = c_reg[i];
      ch_data[32*i +: 32] = c_dat[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (acc_seen[i]) begin
        c_todo[i]--;
        c_seq[i]++;
      end
    end
    apply_ch();
  endtask

  task automatic set_pipe(input logic v, input logic rw, input logic cw, input logic lnk,
                          input logic [4:0] rn, input logic [31:0] d, input logic [31:0] bo,
                          input logic [1:0] sz, input logic [1:0] off, input logic sg);
    wb_valid = v; wb_regwrite = rw; wb_copwrite = cw; wb_link = lnk;
    wb_regnum = rn; wb_data = d; wb_branchout = bo;
    wb_ld_size = sz; wb_ld_off = off; wb_ld_signed = sg;
  endtask

  // Reference load extraction by shifting and masking.
  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] size,
                                           input logic sgn, input logic [1:0] off);
    int unsigned v, bits;
    if (size >= 2'd2) return d;
    bits = (size == 2'd0) ? 8 : 16;
    if (size == 2'd0) v = (d >> (8 * (3 - int'(off)))) & 32'hFF;
    else              v = (d >> (off[1] ? 0 : 16)) & 32'hFFFF;
    if (sgn && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
    return v;
  endfunction

  // Reference model: a queue of pending channel results and a blocked-cycle count.
  typedef struct {
    logic [4:0]  regnum;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_rr = 0;
  int          m_starve = 0;
  logic        m_en = 1'b0, m_cop = 1'b0;
  logic [4:0]  m_num = '0;
  logic [31:0] m_data = '0;
  bit          m_empty, m_full, m_stall, m_ptake, m_ftake;
  int          m_g;
  logic [31:0] m_rdy;

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_en", 32'(writeRegEn), 0);
      check("rst_cop", 32'(writeRegEnCop), 0);
      check("rst_num", 32'(writeRegNum), 0);
      check("rst_data", writeRegData, 0);
      check("rst_count", 32'(fifo_count), 0);
      check("rst_ready", 32'(ch_ready), 0);
      check("rst_stall", 32'(pipe_stall), 0);
      mq.delete();
      m_rr = 0; m_starve = 0;
      m_en = 1'b0; m_cop = 1'b0; m_num = '0; m_data = '0;
    end else begin
      m_empty = (mq.size() == 0);
      m_full  = (mq.size() == FIFO_DEPTH);
      m_stall = (!m_empty && m_starve >= STARVE_LIMIT) || (m_full && ch_valid != '0);
      m_ptake = wb_valid && (wb_regwrite || wb_copwrite) && !m_stall;
      m_ftake = !m_ptake && !m_empty;
      m_g = -1;
      if (!m_full) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (m_g < 0 && ch_valid[(m_rr + k) % NUM_CH]) m_g = (m_rr + k) % NUM_CH;
        end
      end
      m_rdy = (m_g >= 0) ? (32'd1 << m_g) : 32'd0;

      check("model_en", 32'(writeRegEn), 32'(m_en));
      check("model_cop", 32'(writeRegEnCop), 32'(m_cop));
      check("model_num", 32'(writeRegNum), 32'(m_num));
      check("model_data", writeRegData, m_data);
      check("model_count", 32'(fifo_count), mq.size());
      check("model_ready", 32'(ch_ready), m_rdy);
      check("model_stall", 32'(pipe_stall), 32'(m_stall));

      if (m_ptake) begin
        m_en   = wb_regwrite && (wb_regnum != 0);
        m_cop  = wb_copwrite;
        m_num  = wb_regnum;
        m_data = wb_link ? wb_branchout : ref_load(wb_data, wb_ld_size, wb_ld_signed, wb_ld_off);
      end else if (m_ftake) begin
        m_en = (mq[0].regnum != 0); m_cop = 1'b0;
        m_num = mq[0].regnum; m_data = mq[0].data;
      end else begin
        m_en = 1'b0; m_cop = 1'b0; m_num = '0; m_data = '0;
      end
      if (m_ftake || m_empty) m_starve = 0;
      else if (m_ptake)       m_starve++;
      if (m_ftake) void'(mq.pop_front());
      if (m_g >= 0) begin
        mq.push_back('{regnum: c_reg[m_g], data: c_dat[m_g]});
        m_rr = (m_g + 1) % NUM_CH;
      end
    end
  end

  logic [31:0] rdy_tab [4] = '{32'd1, 32'd2, 32'd1, 32'd2};
  logic [31:0] num_tab [4] = '{32'd8, 32'd16, 32'd9, 32'd17};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    set_pipe(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 2'd2, 2'd0, 0);
    for (int i = 0; i < NUM_CH; i++) begin
      c_todo[i] = 0;
      c_seq[i]  = 0;
    end
    apply_ch();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Pipeline data path: word, byte/half loads, link, r0, coprocessor.
    set_pipe(1, 1, 0, 0, 5'd5, 32'h1234_5678, 32'h0, 2'd2, 2'd0, 0);
    tick();
    set_pipe(1, 1, 0, 0, 5'd6, 32'h0080_0000, 32'h0, 2'd0, 2'd1, 1);
    @(negedge clk);
    check("t1_en", 32'(writeRegEn), 1);
    check("t1_num", 32'(writeRegNum), 5);
    check("t1_data", writeRegData, 32'h1234_5678);
    tick();
    set_pipe(1, 1, 0, 0, 5'd7, 32'h0080_0000, 32'h0, 2'd0, 2'd1, 0);
    @(negedge clk);
    check("t2_sbyte", writeRegData, 32'hFFFF_FF80);
    check("t2_num", 32'(writeRegNum), 6);
    tick();
    set_pipe(1, 1, 0, 0, 5'd8, 32'h1234_8001, 32'h0, 2'd1, 2'd2, 1);
    @(negedge clk);
    check("t2_ubyte", writeRegData, 32'h0000_0080);
    tick();
    set_pipe(1, 1, 0, 1, 5'd31, 32'hFFFF_FFFF, 32'h0040_0020, 2'd0, 2'd3, 1);
    @(negedge clk);
    check("t2_shalf", writeRegData, 32'hFFFF_8001);
    tick();
    set_pipe(1, 1, 0, 0, 5'd0, 32'hDEAD_BEEF, 32'h0, 2'd2, 2'd0, 0);
    @(negedge clk);
    check("t3_link", writeRegData, 32'h0040_0020);
    check("t3_link_num", 32'(writeRegNum), 31);
    tick();
    set_pipe(1, 0, 1, 0, 5'd0, 32'hA5A5_A5A5, 32'h0, 2'd2, 2'd0, 0);
    @(negedge clk);
    check("t3_r0_en", 32'(writeRegEn), 0);
    check("t3_r0_data", writeRegData, 32'hDEAD_BEEF);
    tick();
    set_pipe(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 2'd2, 2'd0, 0);
    @(negedge clk);
    check("t3_cop", 32'(writeRegEnCop), 1);
    check("t3_cop_en", 32'(writeRegEn), 0);
    tick();

    // Round-robin between two always-valid channels, pipeline idle.
    c_todo[0] = 2; c_todo[1] = 2;
    apply_ch();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) check("t4_ready", 32'(ch_ready), rdy_tab[k]);
      if (k >= 2) begin
        check("t4_num", 32'(writeRegNum), num_tab[k-2]);
        check("t4_en", 32'(writeRegEn), 1);
      end
      tick();
    end

    // Starvation guard: pipeline busy every cycle while ch0 waits in the queue.
    set_pipe(1, 1, 0, 0, 5'd3, 32'h3333_0000, 32'h0, 2'd2, 2'd0, 0);
    c_todo[0] = 1;
    apply_ch();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("t5_stall", 32'(pipe_stall), (k == 9) ? 1 : 0);
      if (k == 1) check("t5_count", 32'(fifo_count), 1);
      if (k == 10) begin
        check("t5_drain_num", 32'(writeRegNum), 10);
        check("t5_drain_data", writeRegData, 32'hC000_0002);
      end
      tick();
    end

    // Fill the queue, then reset while a queued result is being written.
    c_todo[0] = 3; c_todo[1] = 3;
    apply_ch();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 4) begin
        check("t6_full", 32'(fifo_count), 4);
        check("t6_full_stall", 32'(pipe_stall), 1);
      end
      tick();
    end
    reset_n = 1'b0;
    #1;
    check("t6_rst_en", 32'(writeRegEn), 0);
    check("t6_rst_data", writeRegData, 0);
    check("t6_rst_count", 32'(fifo_count), 0);
    check("t6_rst_ready", 32'(ch_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    set_pipe(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 2'd2, 2'd0, 0);
    c_todo[0] = 0; c_todo[1] = 0;
    apply_ch();
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t6_post_en", 32'(writeRegEn), 0);
      check("t6_post_count", 32'(fifo_count), 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
